morse_encoder: RTL and testbench

Serial Morse transmitter: the counterpart of the `decoder` block. It accepts one letter index per request (A=0 … Z=25) and drives a single-bit on/off keying line. The output uses International Morse timing, measured in units of `UNIT` clock cycles. It is used to generate live stimulus for the decoder and as a standalone keyer.

---
 rtl/morse_encoder.sv | 198 +++++++++++++++++++
 tb/tb_morse_encoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// -----------------------------------------------------------------------------
// morse_encoder
// Serial International Morse keyer. Accepts one letter index per request and
// keys a single on/off line using dot = 1 unit, dash = 3 units, 1-unit gap
// between elements, 3-unit gap after the letter and 7 units for a word space.
// One unit lasts UNIT clock cycles.
//
// Parameters
//   UNIT    clock cycles per Morse time unit (>= 1)
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset; aborts any transmission
//   start   in   request, taken when ready=1 or on the edge that completes
//                the current request (back-to-back with no dead cycle)
//   letter  in   0..25 = A..Z, 26..31 = word space; sampled at acceptance
//   ready   out  idle and able to accept start
//   out     out  keying line, 1 = mark, registered
//   done    out  one-cycle pulse when a request completes
// -----------------------------------------------------------------------------
module morse_encoder #(
    parameter int unsigned UNIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] letter,
    output logic       ready,
    output logic       out,
    output logic       done
);

    localparam int unsigned   CW       = (UNIT > 1) ? $clog2(UNIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        LGAP,
        WGAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    unit_q, unit_d;
    logic [1:0]    elem_q, elem_d;
    logic [2:0]    len_q, len_d;
    logic [3:0]    pat_q, pat_d;     // pat_q[3] is the first element, 1 = dash
    logic          out_q, out_d;
    logic          done_q, done_d;

    logic          unit_tick;
    logic [2:0]    unit_last;
    logic          seg_end;
    logic          accept;
    logic          finish;
    logic          cur_dash;
    logic          last_elem;

    // Code table: {length, pattern}, pattern written first element leftmost.
    function automatic logic [6:0] lookup(input logic [4:0] code);
        logic [6:0] r;
        case (code)
            5'd0:    r = {3'd2, 4'b0100}; // A .-
            5'd1:    r = {3'd4, 4'b1000}; // B -...
            5'd2:    r = {3'd4, 4'b1010}; // C -.-.
            5'd3:    r = {3'd3, 4'b1000}; // D -..
            5'd4:    r = {3'd1, 4'b0000}; // E .
            5'd5:    r = {3'd4, 4'b0010}; // F ..-.
            5'd6:    r = {3'd3, 4'b1100}; // G --.
            5'd7:    r = {3'd4, 4'b0000}; // H ....
            5'd8:    r = {3'd2, 4'b0000}; // I ..
            5'd9:    r = {3'd4, 4'b0111}; // J .---
            5'd10:   r = {3'd3, 4'b1010}; // K -.-
            5'd11:   r = {3'd4, 4'b0100}; // L .-..
            5'd12:   r = {3'd2, 4'b1100}; // M --
            5'd13:   r = {3'd2, 4'b1000}; // N -.
            5'd14:   r = {3'd3, 4'b1110}; // O ---
            5'd15:   r = {3'd4, 4'b0110}; // P .--.
            5'd16:   r = {3'd4, 4'b1101}; // Q --.-
            5'd17:   r = {3'd3, 4'b0100}; // R .-.
            5'd18:   r = {3'd3, 4'b0000}; // S ...
            5'd19:   r = {3'd1, 4'b1000}; // T -
            5'd20:   r = {3'd3, 4'b0010}; // U ..-
            5'd21:   r = {3'd4, 4'b0001}; // V ...-
            5'd22:   r = {3'd3, 4'b0110}; // W .--
            5'd23:   r = {3'd4, 4'b1001}; // X -..-
            5'd24:   r = {3'd4, 4'b1011}; // Y -.--
            5'd25:   r = {3'd4, 4'b1100}; // Z --..
            default: r = '0;              // word space: no elements
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            unit_q  <= '0;
            elem_q  <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            unit_q  <= unit_d;
            elem_q  <= elem_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        unit_d    = unit_q;
        elem_d    = elem_q;
        len_d     = len_q;
        pat_d     = pat_q;
        accept    = 1'b0;
        finish    = 1'b0;

        cur_dash  = pat_q[2'd3 - elem_q];
        last_elem = ({1'b0, elem_q} == (len_q - 3'd1));
        unit_tick = (cyc_q == CYC_LAST);

        // Index of the final unit of the current segment.
        case (state_q)
            MARK:    unit_last = cur_dash ? 3'd2 : 3'd0;
            GAP:     unit_last = 3'd0;
            LGAP:    unit_last = 3'd2;
            WGAP:    unit_last = 3'd6;
            default: unit_last = 3'd0;
        endcase
        seg_end = unit_tick && (unit_q == unit_last);

        if (unit_tick) begin
            cyc_d  = '0;
            unit_d = unit_q + 3'd1;
        end else begin
            cyc_d  = cyc_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                accept = start;
            end
            MARK: begin
                if (seg_end) begin
                    state_d = last_elem ? LGAP : GAP;
                end
            end
            GAP: begin
                if (seg_end) begin
                    state_d = MARK;
                    elem_d  = elem_q + 2'd1;
                end
            end
            LGAP, WGAP: begin
                if (seg_end) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                    // The completing edge also takes a new request, so a held
                    // start chains letters without an idle cycle.
                    accept  = start;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (seg_end || (state_q == IDLE)) begin
            cyc_d  = '0;
            unit_d = '0;
        end

        if (accept) begin
            {len_d, pat_d} = lookup(letter);
            elem_d         = '0;
            cyc_d          = '0;
            unit_d         = '0;
            state_d        = (letter < 5'd26) ? MARK : WGAP;
        end

        done_d = finish;
        out_d  = (state_d == MARK);
    end

    assign ready = (state_q == IDLE);
    assign out   = out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_morse_encoder.sv
// -----------------------------------------------------------------------------
// tb_morse_encoder
// Three encoders (UNIT = 4, 2, 1) share one clock. The driver issues requests;
// at each acceptance it pushes the expected keying waveform, built from the
// textual Morse table, into that instance's queue. A negedge monitor gathers
// the out samples of every busy cycle and, at each done pulse, pops and
// compares length and waveform.
// -----------------------------------------------------------------------------
module tb_morse_encoder;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_s  [NI];
    logic       start_s  [NI];
    logic [4:0] letter_s [NI];
    logic       ready_s  [NI];
    logic       out_s    [NI];
    logic       done_s   [NI];

    morse_encoder #(.UNIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]), .letter(letter_s[0]),
        .ready(ready_s[0]), .out(out_s[0]), .done(done_s[0])
    );
    morse_encoder #(.UNIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]), .letter(letter_s[1]),
        .ready(ready_s[1]), .out(out_s[1]), .done(done_s[1])
    );
    morse_encoder #(.UNIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n_s[2]), .start(start_s[2]), .letter(letter_s[2]),
        .ready(ready_s[2]), .out(out_s[2]), .done(done_s[2])
    );

    string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                          "....", "..", ".---", "-.-", ".-..", "--", "-.",
                          "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                          "...-", ".--", "-..-", "-.--", "--.."};

    typedef struct {
        logic [127:0] w;
        int           n;
        int           l;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    txn_t q2[$];

    int tests = 0;
    int fails = 0;

    logic [127:0] acc  [NI];
    int           alen [NI];

    function automatic int unit_of(input int id);
        case (id)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // Expected busy-period waveform, one bit per cycle.
    function automatic void model(input int l, input int u,
                                  output logic [127:0] w, output int n);
        string s;
        w = '0;
        n = 0;
        if (l > 25) begin
            n = 7 * u;
            return;
        end
        s = MORSE[l];
        for (int j = 0; j < s.len(); j++) begin
            int units;
            units = (s[j] == "-") ? 3 : 1;
            for (int c = 0; c < units * u; c++) begin
                w[n] = 1'b1;
                n++;
            end
            n += (j == s.len() - 1) ? 3 * u : u;
        end
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input txn_t t);
        case (id)
            0:       q0.push_back(t);
            1:       q1.push_back(t);
            default: q2.push_back(t);
        endcase
    endtask

    task automatic finalize(input int i);
        txn_t e;
        bit   have;
        have = 1'b0;
        case (i)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            chk(1'b0, $sformatf("done_expected[%0d]", i), 0, 1);
        end else begin
            tests++;
            if (alen[i] != e.n || acc[i] != e.w) begin
                fails++;
                $display("FAIL wave[%0d] letter=%0d: got len=%0d bits=%h, expected len=%0d bits=%h",
                         i, e.l, alen[i], acc[i], e.n, e.w);
            end
        end
        acc[i]  = '0;
        alen[i] = 0;
    endtask

    // Monitor
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n_s[i]) begin
                acc[i]  = '0;
                alen[i] = 0;
            end else begin
                if (done_s[i]) finalize(i);
                if (!ready_s[i]) begin
                    if (alen[i] < 128) acc[i][alen[i]] = out_s[i];
                    if (alen[i] < 200) alen[i]++;
                end else begin
                    chk(out_s[i] == 1'b0, $sformatf("idle_out[%0d]", i), int'(out_s[i]), 0);
                end
            end
        end
    end

    // Called at #1 after an edge where the DUT is idle or in its final cycle.
    // Returns at #1 after the edge preceding the completing edge.
    task automatic send(input int id, input int l);
        txn_t t;
        model(l, unit_of(id), t.w, t.n);
        t.l          = l;
        start_s[id]  = 1'b1;
        letter_s[id] = 5'(l);
        @(posedge clk);
        push(id, t);
        #1;
        chk(ready_s[id] == 1'b0, $sformatf("accept_ready[%0d]", id), int'(ready_s[id]), 0);
        chk(out_s[id] == t.w[0], $sformatf("accept_out[%0d]", id), int'(out_s[id]), int'(t.w[0]));
        // Busy-time noise on start and letter must be ignored.
        for (int c = 1; c < t.n; c++) begin
            start_s[id]  = 1'($urandom_range(0, 1));
            letter_s[id] = 5'($urandom);
            @(posedge clk);
            #1;
        end
        start_s[id] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_run(input int id, input int count);
        for (int n = 0; n < count; n++) begin
            send(id, int'($urandom_range(0, 31)));
            if ($urandom_range(0, 2) != 0) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n_s[i]  = 1'b0;
            start_s[i]  = 1'b0;
            letter_s[i] = '0;
            acc[i]      = '0;
            alen[i]     = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk(ready_s[i] == 1'b1, $sformatf("reset_ready[%0d]", i), int'(ready_s[i]), 1);
            chk(out_s[i] == 1'b0, $sformatf("reset_out[%0d]", i), int'(out_s[i]), 0);
            chk(done_s[i] == 1'b0, $sformatf("reset_done[%0d]", i), int'(done_s[i]), 0);
        end
        #1;
        for (int i = 0; i < NI; i++) rst_n_s[i] = 1'b1;
        idle_cycles(2);

        // Reset while idle acts before any clock edge.
        #2;
        rst_n_s[0] = 1'b0;
        #1;
        chk(ready_s[0] == 1'b1, "idle_rst_ready", int'(ready_s[0]), 1);
        chk(out_s[0] == 1'b0, "idle_rst_out", int'(out_s[0]), 0);
        chk(done_s[0] == 1'b0, "idle_rst_done", int'(done_s[0]), 0);
        #2;
        rst_n_s[0] = 1'b1;
        idle_cycles(1);

        // UNIT=4: E, Q, word space (with busy start noise).
        send(0, 4);
        idle_cycles(1);
        send(0, 16);
        idle_cycles(2);
        send(0, 26);
        idle_cycles(1);

        // UNIT=4: T aborted by reset in cycle 5 of the dash, then E.
        start_s[0]  = 1'b1;
        letter_s[0] = 5'd19;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk(out_s[0] == 1'b1, "abort_dash_on", int'(out_s[0]), 1);
        rst_n_s[0] = 1'b0;
        #1;
        chk(out_s[0] == 1'b0, "abort_out", int'(out_s[0]), 0);
        chk(ready_s[0] == 1'b1, "abort_ready", int'(ready_s[0]), 1);
        chk(done_s[0] == 1'b0, "abort_done", int'(done_s[0]), 0);
        @(posedge clk);
        #2;
        rst_n_s[0] = 1'b1;
        idle_cycles(1);
        send(0, 4);
        idle_cycles(1);

        // UNIT=2: A then B back-to-back with start held.
        send(1, 0);
        send(1, 1);
        idle_cycles(1);

        rand_run(0, 20);
        rand_run(1, 30);
        rand_run(2, 40);

        idle_cycles(5);
        chk(q0.size() == 0, "pending[0]", q0.size(), 0);
        chk(q1.size() == 0, "pending[1]", q1.size(), 0);
        chk(q2.size() == 0, "pending[2]", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
